// File: rtl/qdec_pkg.sv
// qdec_pkg
// Shared types and helpers for the quadrature decoder counter.
//   state_t   : FSM states (reset, arm/pipeline flush, run)
//   phase_t   : 2-bit phase vector {a, b}
//   next_fwd  : successor of a phase vector in the forward (count-up) sequence
package qdec_pkg;

  typedef enum logic [1:0] {
    ST_RST,
    ST_ARM,
    ST_RUN
  } state_t;

  typedef logic [1:0] phase_t;

  // Forward sequence is 00 -> 10 -> 11 -> 01 -> 00; reverse is its mirror,
  // so a reverse step is detected as prev == next_fwd(current).
  function automatic phase_t next_fwd(input phase_t ab);
    phase_t nxt;
    case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/qdec_counter_if.sv
// qdec_counter_if
// Encoder inputs and position outputs of the quadrature decoder counter.
//   qa, qb : asynchronous encoder phases
//   en     : count enable
//   clr    : synchronous clear of count and err
//   count  : position count (CNT_W bits)
//   dir    : direction of last accepted step (1 = up)
//   step   : one-cycle pulse per accepted step
//   err    : sticky illegal-transition flag
// master drives the encoder/control side, slave is the decoder.
interface qdec_counter_if #(
  parameter int CNT_W = 16
);

  logic             qa;
  logic             qb;
  logic             en;
  logic             clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step;
  logic             err;

  modport master (
    output qa, qb, en, clr,
    input  count, dir, step, err
  );

  modport slave (
    input  qa, qb, en, clr,
    output count, dir, step, err
  );

endinterface

// File: rtl/qdec_sync.sv
// qdec_sync
// Brings one asynchronous encoder phase into the clk domain.
//   clk : rising-edge clock
//   rst : synchronous, active-low reset (clears all stages to 0)
//   d   : asynchronous phase input
//   q   : synchronised (and, with QDEC_FILTER_EN, glitch-filtered) level
// Optional feature macro: QDEC_FILTER_EN adds a glitch filter that accepts a
// new level only after FILT_LEN consecutive identical synchronised samples.
module qdec_sync
`ifdef QDEC_FILTER_EN
#(
  parameter int FILT_LEN = 3
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;
  logic sync;

  // Two-flop synchroniser; meta may go metastable, sync is safe to use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] run_len;
  logic          level;

  // run_len counts consecutive samples that disagree with the accepted
  // level; any sample agreeing with the level restarts the count, so a
  // pulse shorter than FILT_LEN samples never reaches q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_len <= '0;
      level   <= 1'b0;
    end else if (sync == level) begin
      run_len <= '0;
    end else if (run_len == FW'(FILT_LEN - 1)) begin
      level   <= sync;
      run_len <= '0;
    end else begin
      run_len <= run_len + FW'(1);
    end
  end

  assign q = level;
`else
  assign q = sync;
`endif

endmodule

// File: rtl/qdec_counter.sv
// qdec_counter
// Quadrature decoder with wrapping up/down position counter (x4 decoding).
//   clk : rising-edge clock
//   rst : synchronous, active-low reset
//   bus : qdec_counter_if.slave (qa, qb, en, clr in; count, dir, step, err out)
// Parameters: CNT_W count width, RST_VAL value on reset/clr, FILT_LEN filter
// length (2..15, only used when QDEC_FILTER_EN is defined).
// Optional feature macro: QDEC_FILTER_EN (per-phase glitch filter; the arm
// period then grows from 2 to FILT_LEN + 2 cycles).
module qdec_counter
  import qdec_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int RST_VAL  = 50,
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  qdec_counter_if.slave bus
);

`ifdef QDEC_FILTER_EN
  localparam int ARM_LEN = FILT_LEN + 2;
`else
  localparam int ARM_LEN = 2;
`endif
  // Sized for the longer filtered arm period so both builds share one width.
  localparam int ARM_W = $clog2(FILT_LEN + 3);

  logic qa_f;
  logic qb_f;
  phase_t ab;

  qdec_sync
`ifdef QDEC_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
    u_sync_a (.clk(clk), .rst(rst), .d(bus.qa), .q(qa_f));

  qdec_sync
`ifdef QDEC_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
    u_sync_b (.clk(clk), .rst(rst), .d(bus.qb), .q(qb_f));

  assign ab = {qa_f, qb_f};

  state_t           state,   state_next;
  logic [ARM_W-1:0] arm_cnt, arm_next;
  phase_t           prev_ab, prev_next;
  logic [CNT_W-1:0] count_r, count_next;
  logic             dir_r,   dir_next;
  logic             step_r,  step_next;
  logic             err_r,   err_next;

  // State and output registers; reset loads the RST values and clears the
  // remembered phase so the FSM re-arms from scratch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_RST;
      arm_cnt <= '0;
      prev_ab <= '0;
      count_r <= CNT_W'(RST_VAL);
      dir_r   <= 1'b1;
      step_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_next;
      arm_cnt <= arm_next;
      prev_ab <= prev_next;
      count_r <= count_next;
      dir_r   <= dir_next;
      step_r  <= step_next;
      err_r   <= err_next;
    end
  end

  // Next-state and transition decode. ARM waits for the synchroniser (and
  // filter) to hold real input levels before capturing prev_ab, so the first
  // RUN comparison never sees a spurious edge from the reset zeros.
  // With en low the phase is still tracked and illegal jumps still flagged,
  // only count/dir/step freeze. clr wins over a same-cycle step, dropping it
  // entirely (dir included), but leaves the FSM and prev_ab alone.
  always_comb begin
    state_next = state;
    arm_next   = arm_cnt;
    prev_next  = prev_ab;
    count_next = count_r;
    dir_next   = dir_r;
    step_next  = 1'b0;
    err_next   = err_r;

    case (state)
      ST_RST: begin
        state_next = ST_ARM;
        arm_next   = '0;
      end
      ST_ARM: begin
        if (arm_cnt == ARM_W'(ARM_LEN - 1)) begin
          prev_next  = ab;
          state_next = ST_RUN;
        end else begin
          arm_next = arm_cnt + ARM_W'(1);
        end
      end
      ST_RUN: begin
        prev_next = ab;
        if (ab == next_fwd(prev_ab)) begin
          if (bus.en) begin
            count_next = count_r + CNT_W'(1);
            dir_next   = 1'b1;
            step_next  = 1'b1;
          end
        end else if (prev_ab == next_fwd(ab)) begin
          if (bus.en) begin
            count_next = count_r - CNT_W'(1);
            dir_next   = 1'b0;
            step_next  = 1'b1;
          end
        end else if (ab != prev_ab) begin
          err_next = 1'b1;
        end
      end
      default: state_next = ST_RST;
    endcase

    if (bus.clr) begin
      count_next = CNT_W'(RST_VAL);
      err_next   = 1'b0;
      step_next  = 1'b0;
      dir_next   = dir_r;
    end
  end

  assign bus.count = count_r;
  assign bus.dir   = dir_r;
  assign bus.step  = step_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_qdec_counter.sv
// tb_qdec_counter
// Self-checking bench for qdec_counter. Two instances share one stimulus
// stream: a 16-bit counter (RST_VAL 50) and a 4-bit counter (RST_VAL 1) that
// exercises wrap-around. Expected values come from a position model that
// walks an index around the four-phase cycle and counts steps arithmetically.
// Honours QDEC_FILTER_EN (FILT_LEN 3) for latency and arm length.
module tb_qdec_counter;
  import qdec_pkg::*;

`ifdef QDEC_FILTER_EN
  localparam int FILT    = 3;
  localparam int LAT     = FILT + 2;
  localparam int ARM_LEN = FILT + 2;
`else
  localparam int FILT    = 3;
  localparam int LAT     = 2;
  localparam int ARM_LEN = 2;
`endif

  typedef enum int {ACT_HOLD, ACT_FWD, ACT_REV, ACT_BAD} action_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic qa, qb, en, clr;

  always #5 clk = ~clk;

  qdec_counter_if #(.CNT_W(16)) bus16 ();
  qdec_counter_if #(.CNT_W(4))  bus4 ();

  assign bus16.qa  = qa;
  assign bus16.qb  = qb;
  assign bus16.en  = en;
  assign bus16.clr = clr;
  assign bus4.qa   = qa;
  assign bus4.qb   = qb;
  assign bus4.en   = en;
  assign bus4.clr  = clr;

  qdec_counter #(.CNT_W(16), .RST_VAL(50), .FILT_LEN(FILT)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16)
  );

  qdec_counter #(.CNT_W(4), .RST_VAL(1), .FILT_LEN(FILT)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int tests_run;
  int tests_failed;

  // Reference model: position index into the forward cycle plus expected
  // outputs for both counter widths.
  phase_t seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int pos;
  int cnt16;
  int cnt4;
  bit dir_exp;
  bit step_exp;
  bit err_exp;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_count16"}, int'(bus16.count), cnt16);
    checkOutput({tag, "_count4"},  int'(bus4.count),  cnt4);
    checkOutput({tag, "_dir16"},   int'(bus16.dir),   int'(dir_exp));
    checkOutput({tag, "_dir4"},    int'(bus4.dir),    int'(dir_exp));
    checkOutput({tag, "_step16"},  int'(bus16.step),  int'(step_exp));
    checkOutput({tag, "_step4"},   int'(bus4.step),   int'(step_exp));
    checkOutput({tag, "_err16"},   int'(bus16.err),   int'(err_exp));
    checkOutput({tag, "_err4"},    int'(bus4.err),    int'(err_exp));
  endtask

  // Hold reset three cycles, then watch the arm period: reset values hold
  // and no step may appear.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    clr = 1'b0;
    cnt16    = 50;
    cnt4     = 1;
    dir_exp  = 1'b1;
    step_exp = 1'b0;
    err_exp  = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("reset");
    rst = 1'b1;
    for (int i = 0; i < ARM_LEN + 3; i++) begin
      @(negedge clk);
      checkAll("arm");
    end
  endtask

  // One encoder transaction: move the phases, check nothing changes before
  // the latency has elapsed, pulse clr (if asked) on the cycle the step lands,
  // check the result and that the step pulse lasts exactly one cycle.
  task automatic applyStimulus(input action_t act, input bit en_v, input bit clr_v, input string tag);
    int     np;
    phase_t nab;
    case (act)
      ACT_FWD: np = (pos + 1) % 4;
      ACT_REV: np = (pos + 3) % 4;
      ACT_BAD: np = (pos + 2) % 4;
      default: np = pos;
    endcase
    nab = seq[np];
    @(negedge clk);
    qa  = nab[1];
    qb  = nab[0];
    en  = en_v;
    clr = 1'b0;
    step_exp = 1'b0;
    @(negedge clk);
    checkAll({tag, "_pre"});
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      checkAll({tag, "_pre"});
    end
    clr = clr_v;
    @(negedge clk);
    pos = np;
    if (clr_v) begin
      cnt16   = 50;
      cnt4    = 1;
      err_exp = 1'b0;
    end else if (act == ACT_BAD) begin
      err_exp = 1'b1;
    end else if (en_v && act == ACT_FWD) begin
      cnt16    = (cnt16 + 1) % 65536;
      cnt4     = (cnt4 + 1) % 16;
      dir_exp  = 1'b1;
      step_exp = 1'b1;
    end else if (en_v && act == ACT_REV) begin
      cnt16    = (cnt16 + 65535) % 65536;
      cnt4     = (cnt4 + 15) % 16;
      dir_exp  = 1'b0;
      step_exp = 1'b1;
    end
    checkAll(tag);
    clr = 1'b0;
    @(negedge clk);
    step_exp = 1'b0;
    checkAll({tag, "_tail"});
  endtask

  initial begin
    int r;
    action_t act;
    tests_run    = 0;
    tests_failed = 0;
    qa  = 1'b1;
    qb  = 1'b1;
    en  = 1'b1;
    clr = 1'b0;
    pos = 2;

    doReset();

    // 11 -> 01 -> 00, then two full forward cycles.
    applyStimulus(ACT_FWD, 1'b1, 1'b0, "to00");
    applyStimulus(ACT_FWD, 1'b1, 1'b0, "to00");
    for (int i = 0; i < 8; i++) applyStimulus(ACT_FWD, 1'b1, 1'b0, "fwd");
    checkOutput("fwd8_total", int'(bus16.count), 60);

    // 00 -> 11 is illegal; clr then restores count and err.
    applyStimulus(ACT_BAD, 1'b1, 1'b0, "illegal");
    checkOutput("illegal_err", int'(bus16.err), 1);
    applyStimulus(ACT_HOLD, 1'b1, 1'b1, "clr");

    // Reverse from 11 on the 4-bit instance: 1 -> 0 -> 15 -> 14.
    for (int i = 0; i < 3; i++) applyStimulus(ACT_REV, 1'b1, 1'b0, "rev");
    checkOutput("wrap4_total", int'(bus4.count), 14);

    // clr on the same cycle as a step.
    applyStimulus(ACT_FWD, 1'b1, 1'b1, "clr_prio");

    // en low over four forward edges, then one counted edge.
    for (int i = 0; i < 4; i++) applyStimulus(ACT_FWD, 1'b0, 1'b0, "en_off");
    applyStimulus(ACT_FWD, 1'b1, 1'b0, "en_on");

`ifdef QDEC_FILTER_EN
    // Two-cycle glitch on qa must never reach the counter.
    @(negedge clk);
    qa = ~qa;
    repeat (2) @(negedge clk);
    qa = ~qa;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkAll("glitch");
    end
`endif

    // Randomised traffic, with occasional enable drops and clears.
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)       act = ACT_FWD;
      else if (r < 7)  act = ACT_REV;
      else if (r < 8)  act = ACT_HOLD;
      else             act = ACT_BAD;
      applyStimulus(act, ($urandom_range(0, 5) != 0), ($urandom_range(0, 7) == 0), "rand");
    end

    // Reset in mid-operation, then a little more traffic.
    doReset();
    for (int n = 0; n < 20; n++) begin
      act = ($urandom_range(0, 1) == 0) ? ACT_FWD : ACT_REV;
      applyStimulus(act, 1'b1, 1'b0, "post_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
